// File: rtl/spl_rd_pkg.sv
// Shared definitions for the SPL read-request arbiter.
//   - Field offsets for the SPL TX read header and the RX response header.
//   - RDLINE request type code.
//   - mdata packing: {4'b0, port[1:0], tag[7:0]} travels with the request
//     and comes back in the response header, so responses can be routed.
//   - Arbiter FSM state type.
//   - build_rd_hdr(): assembles a complete TX read header.
package spl_rd_pkg;

  localparam int TXHDR_W      = 99;
  localparam int TX_TYPE_LSB  = 52;
  localparam int TX_TYPE_W    = 4;
  localparam int TX_ADDR_LSB  = 14;
  localparam int TX_ADDR_W    = 32;
  localparam int TX_MDATA_LSB = 0;
  localparam int MDATA_W      = 14;
  localparam int MD_PORT_W    = 2;
  localparam int MD_TAG_W     = 8;

  localparam logic [TX_TYPE_W-1:0] TX_TYPE_RDLINE = 4'h4;

  // The response header echoes mdata in its low bits.
  localparam int RX_TAG_LSB  = 0;
  localparam int RX_TAG_W    = MD_TAG_W;
  localparam int RX_PORT_LSB = 8;
  localparam int RX_PORT_W   = MD_PORT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  function automatic logic [MDATA_W-1:0] pack_mdata(
    input logic [MD_PORT_W-1:0] port,
    input logic [MD_TAG_W-1:0]  tag
  );
    return {4'b0000, port, tag};
  endfunction

  function automatic logic [TXHDR_W-1:0] build_rd_hdr(
    input logic [TX_ADDR_W-1:0] addr,
    input logic [MD_PORT_W-1:0] port,
    input logic [MD_TAG_W-1:0]  tag
  );
    logic [TXHDR_W-1:0] hdr;
    hdr = '0;
    hdr[TX_TYPE_LSB  +: TX_TYPE_W] = TX_TYPE_RDLINE;
    hdr[TX_ADDR_LSB  +: TX_ADDR_W] = addr;
    hdr[TX_MDATA_LSB +: MDATA_W]   = pack_mdata(port, tag);
    return hdr;
  endfunction

endpackage

// File: rtl/spl_rd_arbiter_rr.sv
// Round-robin selector.
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : per-requester request (already qualified by the caller)
//   advance_i  : a grant was taken this cycle; move the pointer to it
//   gnt_o      : one-hot (or zero) grant, combinational from req_i
// The winner is the lowest requesting index strictly after the last
// granted index, wrapping. The pointer resets to NUM_REQ-1 so that
// requester 0 wins first.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_d;
  logic [PTR_W-1:0] cand;
  logic             found;

  function automatic logic [PTR_W-1:0] wrap_idx(
    input logic [PTR_W-1:0] base,
    input int               off
  );
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_idx(last_q, k);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        last_d      = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PTR_W'(NUM_REQ - 1);
    end else if (advance_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spl_rd_arbiter.sv
// SPL read-request arbiter.
// Multiplexes NUM_REQ read requesters onto the single SPL TX read channel
// and routes RX read responses back to the requester encoded in mdata.
//   clk, spl_reset          : clock, asynchronous active-high reset
//   spl_enable              : high = run; low = stop granting and drain
//   spl_tx_rd_almostfull    : TX back-pressure, blocks all grants
//   afu_tx_rd_valid/_hdr    : registered TX read request (1 cycle after grant)
//   spl_rx_rd_valid/_hdr0/_data : RX read response
//   req_valid/_ready/_addr/_tag : per-requester request handshake
//   rsp_valid/_tag/_data    : registered, one-hot routed response
//   idle                    : nothing outstanding and nothing being issued
//   err                     : sticky, set by any response that cannot be routed
module spl_rd_arbiter
  import spl_rd_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_OUTST   = 32,
  parameter int ADDR_W      = 32,
  parameter int TAG_W       = 8,
  parameter int TXHDR_WIDTH = 99,
  parameter int RXHDR_WIDTH = 24,
  parameter int CACHE_WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       spl_reset,
  input  logic                       spl_enable,
  input  logic                       spl_tx_rd_almostfull,
  output logic                       afu_tx_rd_valid,
  output logic [TXHDR_WIDTH-1:0]     afu_tx_rd_hdr,
  input  logic                       spl_rx_rd_valid,
  input  logic [RXHDR_WIDTH-1:0]     spl_rx_hdr0,
  input  logic [CACHE_WIDTH-1:0]     spl_rx_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [CACHE_WIDTH-1:0]     rsp_data,
  output logic                       idle,
  output logic                       err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  rd_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q [NUM_REQ];
  logic                   afu_tx_rd_valid_q;
  logic [TXHDR_WIDTH-1:0] afu_tx_rd_hdr_q;
  logic [TXHDR_WIDTH-1:0] afu_tx_rd_hdr_d;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [TAG_W-1:0]       rsp_tag_q;
  logic [CACHE_WIDTH-1:0] rsp_data_q;
  logic                   err_q;

  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     inc;
  logic [NUM_REQ-1:0]     dec;
  logic                   all_zero;
  logic [RX_PORT_W-1:0]   rx_port;
  logic                   rx_routable;

  // Header bits above the port field carry nothing this block uses.
  logic unused_rx_hdr_bits;
  assign unused_rx_hdr_bits = ^spl_rx_hdr0[RXHDR_WIDTH-1:RX_PORT_LSB+RX_PORT_W];

  // Grant qualification: requests only compete while running, unthrottled
  // and below their outstanding limit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST)) &&
                (state_q == ST_RUN) && !spl_tx_rd_almostfull;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (spl_reset),
    .req_i     (elig),
    .advance_i (|gnt),
    .gnt_o     (gnt)
  );

  assign req_ready = gnt;
  assign inc       = gnt & req_valid;

  always_comb begin
    afu_tx_rd_hdr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        afu_tx_rd_hdr_d = TXHDR_WIDTH'(build_rd_hdr(
                            TX_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]),
                            MD_PORT_W'(i),
                            MD_TAG_W'(req_tag[i*TAG_W +: TAG_W])));
      end
    end
  end

  // A response is routable only when its port names a real requester that
  // actually has a read outstanding; a port >= NUM_REQ matches no index.
  assign rx_port = spl_rx_hdr0[RX_PORT_LSB +: RX_PORT_W];

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i] = spl_rx_rd_valid && (rx_port == RX_PORT_W'(i)) && (cnt_q[i] != '0);
    end
  end

  assign rx_routable = |dec;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  // Outstanding counters: a grant and a routed response to the same
  // requester in one cycle cancel out.
  always_ff @(posedge clk or posedge spl_reset) begin
    if (spl_reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Run/drain control. A returning enable during drain resumes directly.
  always_ff @(posedge clk or posedge spl_reset) begin
    if (spl_reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (spl_enable) state_q <= ST_RUN;
        ST_RUN:   if (!spl_enable) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (spl_enable)    state_q <= ST_RUN;
          else if (all_zero) state_q <= ST_IDLE;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge spl_reset) begin
    if (spl_reset) begin
      afu_tx_rd_valid_q <= 1'b0;
      afu_tx_rd_hdr_q   <= '0;
      rsp_valid_q       <= '0;
      rsp_tag_q         <= '0;
      rsp_data_q        <= '0;
      err_q             <= 1'b0;
    end else begin
      afu_tx_rd_valid_q <= |inc;
      if (|inc) afu_tx_rd_hdr_q <= afu_tx_rd_hdr_d;
      rsp_valid_q <= dec;
      if (rx_routable) begin
        rsp_tag_q  <= TAG_W'(spl_rx_hdr0[RX_TAG_LSB +: RX_TAG_W]);
        rsp_data_q <= spl_rx_data;
      end
      if (spl_rx_rd_valid && !rx_routable) err_q <= 1'b1;
    end
  end

  assign afu_tx_rd_valid = afu_tx_rd_valid_q;
  assign afu_tx_rd_hdr   = afu_tx_rd_hdr_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_tag         = rsp_tag_q;
  assign rsp_data        = rsp_data_q;
  assign err             = err_q;

  // A request registered for TX this cycle counts as activity even though
  // the counters already include it.
  assign idle = (state_q == ST_IDLE) ||
                ((state_q == ST_RUN) && all_zero && !afu_tx_rd_valid_q);

endmodule

// File: tb/tb_spl_rd_arbiter.sv
// Self-checking bench for spl_rd_arbiter: directed scenarios followed by a
// randomized run, all compared against a behavioural reference model.
module tb_spl_rd_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         spl_reset;
  logic         spl_enable;
  logic         spl_tx_rd_almostfull;
  logic         afu_tx_rd_valid;
  logic [98:0]  afu_tx_rd_hdr;
  logic         spl_rx_rd_valid;
  logic [23:0]  spl_rx_hdr0;
  logic [511:0] spl_rx_data;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*32-1:0] req_addr;
  logic [N*8-1:0]  req_tag;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_tag;
  logic [511:0] rsp_data;
  logic         idle;
  logic         err;

  always #5 clk = ~clk;

  spl_rd_arbiter dut (
    .clk                  (clk),
    .spl_reset            (spl_reset),
    .spl_enable           (spl_enable),
    .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
    .afu_tx_rd_valid      (afu_tx_rd_valid),
    .afu_tx_rd_hdr        (afu_tx_rd_hdr),
    .spl_rx_rd_valid      (spl_rx_rd_valid),
    .spl_rx_hdr0          (spl_rx_hdr0),
    .spl_rx_data          (spl_rx_data),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_tag              (req_tag),
    .rsp_valid            (rsp_valid),
    .rsp_tag              (rsp_tag),
    .rsp_data             (rsp_data),
    .idle                 (idle),
    .err                  (err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_e;
  mstate_e      m_state;
  int           m_cnt [N];
  int           m_last;
  logic         m_err;
  logic         m_tx_vld;
  logic [98:0]  m_tx_hdr;
  logic [N-1:0] m_rsp_vld;
  logic [7:0]   m_rsp_tag;
  logic [511:0] m_rsp_data;
  logic [N-1:0] obs_rdy;

  function automatic logic [98:0] model_hdr(input logic [31:0] a, input int port, input logic [7:0] t);
    logic [98:0] h;
    h = 99'(4) << 52;
    h = h | (99'(a) << 14);
    h = h | (99'(port) << 8) | 99'(t);
    return h;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    m_state = M_IDLE;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last     = N - 1;
    m_err      = 1'b0;
    m_tx_vld   = 1'b0;
    m_tx_hdr   = '0;
    m_rsp_vld  = '0;
    m_rsp_tag  = '0;
    m_rsp_data = '0;
  endtask

  // Called just after a rising edge with inputs set; checks at the falling
  // edge, steps the model at the next rising edge, returns 1 time unit later.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int  win;
    int  dec;
    int  p;
    int  cand;
    bit  all0;
    logic exp_idle;
    @(negedge clk);
    win = -1;
    for (int k = 1; k <= N; k++) begin
      cand = (m_last + k) % N;
      if (win < 0 && req_valid[cand] && m_cnt[cand] < 32 && m_state == M_RUN && !spl_tx_rd_almostfull)
        win = cand;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all0 = 1'b0;
    exp_idle = (m_state == M_IDLE) || (m_state == M_RUN && all0 && !m_tx_vld);
    obs_rdy = req_ready;
    chk("ready", req_ready, exp_rdy);
    chk("idle", idle, exp_idle);
    chk("tx_vld", afu_tx_rd_valid, m_tx_vld);
    if (m_tx_vld) chk("tx_hdr", afu_tx_rd_hdr, m_tx_hdr);
    chk("rsp_vld", rsp_valid, m_rsp_vld);
    if (m_rsp_vld != '0) begin
      chk("rsp_tag", rsp_tag, m_rsp_tag);
      chk("rsp_data", rsp_data, m_rsp_data);
    end
    chk("err", err, m_err);
    @(posedge clk);
    m_tx_vld = (win >= 0);
    if (win >= 0) begin
      m_tx_hdr = model_hdr(req_addr[win*32 +: 32], win, req_tag[win*8 +: 8]);
      m_last   = win;
    end
    m_rsp_vld = '0;
    dec = -1;
    if (spl_rx_rd_valid) begin
      p = int'(spl_rx_hdr0[9:8]);
      if (p < N && m_cnt[p] > 0) begin
        m_rsp_vld[p] = 1'b1;
        m_rsp_tag    = spl_rx_hdr0[7:0];
        m_rsp_data   = spl_rx_data;
        dec          = p;
      end else begin
        m_err = 1'b1;
      end
    end
    if (win >= 0) m_cnt[win]++;
    if (dec >= 0) m_cnt[dec]--;
    case (m_state)
      M_IDLE:  if (spl_enable) m_state = M_RUN;
      M_RUN:   if (!spl_enable) m_state = M_DRAIN;
      default: begin
        if (spl_enable) m_state = M_RUN;
        else if (all0)  m_state = M_IDLE;
      end
    endcase
    #1;
  endtask

  task automatic do_reset();
    spl_reset = 1'b1;
    #2;
    chk("rst_txv",  afu_tx_rd_valid, 1'b0);
    chk("rst_hdr",  afu_tx_rd_hdr, '0);
    chk("rst_rspv", rsp_valid, '0);
    chk("rst_tag",  rsp_tag, '0);
    chk("rst_data", rsp_data, '0);
    chk("rst_err",  err, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rdy",  req_ready, '0);
    model_clear();
    @(posedge clk);
    #1;
    spl_reset = 1'b0;
  endtask

  logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] rr_seq [5];

  initial begin
    spl_reset = 1'b0; spl_enable = 1'b0; spl_tx_rd_almostfull = 1'b0;
    req_valid = '0; req_addr = '0; req_tag = '0;
    spl_rx_rd_valid = 1'b0; spl_rx_hdr0 = '0; spl_rx_data = '0;
    model_clear();
    #1;

    // Single request, header layout
    do_reset();
    spl_enable = 1'b1; cycle();
    req_valid = 4'b0001; req_addr[31:0] = 32'h100; req_tag[7:0] = 8'h5A; cycle();
    req_valid = '0;
    chk("d_tx_vld",   afu_tx_rd_valid, 1'b1);
    chk("d_hdr_addr", afu_tx_rd_hdr[45:14], 32'h100);
    chk("d_hdr_md",   afu_tx_rd_hdr[13:0], 14'h005A);
    chk("d_hdr_type", afu_tx_rd_hdr[55:52], 4'h4);
    cycle();

    // Round-robin order with all requesters active
    do_reset();
    spl_enable = 1'b1; cycle();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32] = $urandom;
      req_tag[i*8 +: 8]    = 8'($urandom);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      rr_seq[k] = obs_rdy;
    end
    for (int k = 0; k < 5; k++) chk($sformatf("rr_%0d", k), rr_seq[k], rr_exp[k]);

    // Back-pressure blocks everything
    spl_tx_rd_almostfull = 1'b1;
    cycle();
    chk("af_rdy", obs_rdy, '0);
    cycle();
    chk("af_txv", afu_tx_rd_valid, 1'b0);
    spl_tx_rd_almostfull = 1'b0; req_valid = '0;

    // Outstanding limit on requester 2
    do_reset();
    spl_enable = 1'b1; cycle();
    req_valid = 4'b0100;
    for (int k = 0; k < 32; k++) cycle();
    cycle();
    chk("lim_blk", obs_rdy, '0);
    spl_rx_rd_valid = 1'b1; spl_rx_hdr0 = 24'h000207; spl_rx_data = rand512();
    cycle();
    spl_rx_rd_valid = 1'b0;
    chk("lim_rspv", rsp_valid, 4'b0100);
    chk("lim_tag",  rsp_tag, 8'h07);
    cycle();
    chk("lim_unblk", obs_rdy, 4'b0100);
    req_valid = '0;

    // Drain with three outstanding, then a stray response
    do_reset();
    spl_enable = 1'b1; cycle();
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) cycle();
    req_valid = '0; spl_enable = 1'b0;
    cycle();
    chk("drn_idle0", idle, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      spl_rx_rd_valid = 1'b1; spl_rx_hdr0 = {14'h0, 2'd0, 8'(k)}; spl_rx_data = rand512();
      cycle();
    end
    spl_rx_rd_valid = 1'b0;
    cycle();
    chk("drn_idle1", idle, 1'b1);
    spl_rx_rd_valid = 1'b1; spl_rx_hdr0 = 24'h000033;
    cycle();
    spl_rx_rd_valid = 1'b0;
    chk("drn_err", err, 1'b1);
    cycle();

    // Reset with reads in flight; their late responses are unroutable
    do_reset();
    spl_enable = 1'b1; cycle();
    req_valid = 4'b0010; cycle(); cycle();
    req_valid = '0;
    do_reset();
    spl_enable = 1'b1; cycle();
    spl_rx_rd_valid = 1'b1; spl_rx_hdr0 = 24'h000144;
    cycle();
    spl_rx_rd_valid = 1'b0;
    chk("late_err", err, 1'b1);

    // Randomized traffic
    do_reset();
    spl_enable = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      int p;
      if ($urandom_range(0, 49) == 0) spl_enable = ~spl_enable;
      spl_tx_rd_almostfull = ($urandom_range(0, 9) == 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*32 +: 32] = $urandom;
        req_tag[i*8 +: 8]    = 8'($urandom);
      end
      spl_rx_rd_valid = 1'b0;
      if ($urandom_range(0, 9) < 6) begin
        p = $urandom_range(0, N - 1);
        if (m_cnt[p] > 0) begin
          spl_rx_rd_valid = 1'b1;
          spl_rx_hdr0     = {14'($urandom), 2'(p), 8'($urandom)};
          spl_rx_data     = rand512();
        end
      end
      cycle();
    end
    spl_rx_rd_valid = 1'b0; req_valid = '0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
